// File: rtl/xxx_pkg.sv
// Shared types and defaults for the xxx receive buffer slice.
package xxx_pkg;

  localparam int XXX_ADDR_W = 8;
  localparam int XXX_DATA_W = 8;
  localparam int XXX_DEPTH  = 8;

  // One captured sample as it sits in the buffer.
  typedef struct packed {
    logic [XXX_ADDR_W-1:0] addr;
    logic [XXX_DATA_W-1:0] data;
  } xxx_sample_t;

  // Address-sequence checker: disarmed until the first sample after reset/clear.
  typedef enum logic {
    SEQ_DISARMED = 1'b0,
    SEQ_ARMED    = 1'b1
  } seq_state_e;

  // Pointer width: index bits plus one wrap bit to tell full from empty.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int XXX_PTR_W = ptrWidth(XXX_DEPTH);

endpackage

// File: rtl/xxx_rx_buf_mem.sv
// Sample storage: one write port, asynchronous read port, no reset on contents.
module xxx_rx_buf_mem
  import xxx_pkg::*;
#(
  parameter int  DEPTH = XXX_DEPTH,
  parameter type T     = xxx_sample_t
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  T                         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output T                         o_rdata
);

  T r_mem [DEPTH];

  // Write the accepted sample into its slot; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/xxx_rx_buf.sv
// Receive buffer behind xxx: FIFO with fall-through output, overflow/drop
// accounting and an address-sequence checker.
module xxx_rx_buf
  import xxx_pkg::*;
#(
  parameter int ADDR_WIDTH = XXX_ADDR_W,
  parameter int DATA_WIDTH = XXX_DATA_W,
  parameter int DEPTH      = XXX_DEPTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     xxx_dt_valid_i,
  input  logic [ADDR_WIDTH-1:0]    xxx_addr_i,
  input  logic [DATA_WIDTH-1:0]    xxx_dt_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [ADDR_WIDTH-1:0]    out_addr_o,
  output logic [DATA_WIDTH-1:0]    out_dt_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o,
  output logic                     seq_err_o
);

  localparam int PTR_W = ptrWidth(DEPTH);
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } sample_t;

  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  sample_t               w_wrData;
  sample_t               w_rdData;
  logic                  r_ovf;
  logic [CNT_WIDTH-1:0]  r_dropCnt;
  logic                  r_seqErr;
  logic [ADDR_WIDTH-1:0] r_expAddr;
  seq_state_e            r_seqState;
  seq_state_e            w_seqStateNext;
  logic                  w_seqErrSet;

  // Full/empty come from the registered pointers, so a pop in the same
  // cycle never frees room for a push against a full buffer.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]) &&
                   (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
  assign w_push  = xxx_dt_valid_i && !w_full && !clr_i;
  assign w_drop  = xxx_dt_valid_i &&  w_full && !clr_i;
  assign w_pop   = !w_empty && out_ready_i && !clr_i;

  assign w_wrData = '{addr: xxx_addr_i, data: xxx_dt_i};

  xxx_rx_buf_mem #(
    .DEPTH (DEPTH),
    .T     (sample_t)
  ) u_mem (
    .i_clk   (clk_i),
    .i_we    (w_push),
    .i_waddr (r_wrPtr[IDX_W-1:0]),
    .i_wdata (w_wrData),
    .i_raddr (r_rdPtr[IDX_W-1:0]),
    .o_rdata (w_rdData)
  );

  assign out_valid_o = !w_empty;
  assign out_addr_o  = w_empty ? '0 : w_rdData.addr;
  assign out_dt_o    = w_empty ? '0 : w_rdData.data;
  assign level_o     = r_wrPtr - r_rdPtr;
  assign ovf_o       = r_ovf;
  assign drop_cnt_o  = r_dropCnt;
  assign seq_err_o   = r_seqErr;

  // Advance write/read pointers on accepted pushes and handshaken pops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (clr_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Sticky overflow flag and saturating count of samples lost to a full buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf     <= 1'b0;
      r_dropCnt <= '0;
    end else if (clr_i) begin
      r_ovf     <= 1'b0;
      r_dropCnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_dropCnt != '1) r_dropCnt <= r_dropCnt + CNT_WIDTH'(1);
    end
  end

  // Sequence checker decision: every strobed sample arms the checker, and an
  // armed checker flags any address other than the expected successor.
  always_comb begin
    w_seqStateNext = r_seqState;
    w_seqErrSet    = 1'b0;
    if (xxx_dt_valid_i) begin
      w_seqStateNext = SEQ_ARMED;
      if ((r_seqState == SEQ_ARMED) && (xxx_addr_i != r_expAddr)) begin
        w_seqErrSet = 1'b1;
      end
    end
  end

  // Sequence checker state, expected next address and sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_seqState <= SEQ_DISARMED;
      r_expAddr  <= '0;
      r_seqErr   <= 1'b0;
    end else if (clr_i) begin
      r_seqState <= SEQ_DISARMED;
      r_expAddr  <= '0;
      r_seqErr   <= 1'b0;
    end else begin
      r_seqState <= w_seqStateNext;
      if (xxx_dt_valid_i) r_expAddr <= xxx_addr_i + ADDR_WIDTH'(1);
      if (w_seqErrSet)    r_seqErr  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xxx_rx_buf.sv
// Directed, scoreboard-checked bench for the xxx receive buffer.
module tb_xxx_rx_buf;
  import xxx_pkg::*;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic       clr_i;
  logic       xxx_dt_valid_i;
  logic [7:0] xxx_addr_i;
  logic [7:0] xxx_dt_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_addr_o;
  logic [7:0] out_dt_o;
  logic [3:0] level_o;
  logic       ovf_o;
  logic [7:0] drop_cnt_o;
  logic       seq_err_o;

  logic       v2;
  logic [7:0] a2;
  logic [7:0] d2;
  logic       ready2;
  logic       valid2;
  logic [7:0] addr2;
  logic [7:0] dt2;
  logic [3:0] level2;
  logic       ovf2;
  logic [1:0] drop2;
  logic       seq2;

  int checks = 0;
  int errors = 0;
  xxx_sample_t sb[$];

  xxx_rx_buf #(
    .ADDR_WIDTH (8), .DATA_WIDTH (8), .DEPTH (DEPTH), .CNT_WIDTH (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clr_i          (clr_i),
    .xxx_dt_valid_i (xxx_dt_valid_i),
    .xxx_addr_i     (xxx_addr_i),
    .xxx_dt_i       (xxx_dt_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_addr_o     (out_addr_o),
    .out_dt_o       (out_dt_o),
    .level_o        (level_o),
    .ovf_o          (ovf_o),
    .drop_cnt_o     (drop_cnt_o),
    .seq_err_o      (seq_err_o)
  );

  // Narrow drop counter instance used to exercise saturation.
  xxx_rx_buf #(
    .ADDR_WIDTH (8), .DATA_WIDTH (8), .DEPTH (DEPTH), .CNT_WIDTH (2)
  ) dut2 (
    .clk_i          (clk),
    .rst_i          (rst),
    .clr_i          (clr_i),
    .xxx_dt_valid_i (v2),
    .xxx_addr_i     (a2),
    .xxx_dt_i       (d2),
    .out_valid_o    (valid2),
    .out_ready_i    (ready2),
    .out_addr_o     (addr2),
    .out_dt_o       (dt2),
    .level_o        (level2),
    .ovf_o          (ovf2),
    .drop_cnt_o     (drop2),
    .seq_err_o      (seq2)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic on the main instance, called at a falling edge.
  // Outputs are checked against the scoreboard before the new inputs are
  // driven; a pop retires the scoreboard head, an accepted push appends.
  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] d,
                               input logic rdy);
    xxx_sample_t head;
    bit wasFull;
    checkOutput("valid", 32'(out_valid_o), 32'(sb.size() != 0));
    checkOutput("level", 32'(level_o), 32'(sb.size()));
    wasFull = (sb.size() == DEPTH);
    if (sb.size() == 0) begin
      checkOutput("emptyAddr", 32'(out_addr_o), 32'h0);
    end else if (rdy) begin
      head = sb.pop_front();
      checkOutput("headAddr", 32'(out_addr_o), 32'(head.addr));
      checkOutput("headData", 32'(out_dt_o), 32'(head.data));
    end
    if (v && !wasFull) sb.push_back('{addr: a, data: d});
    xxx_dt_valid_i = v;
    xxx_addr_i     = a;
    xxx_dt_i       = d;
    out_ready_i    = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Synchronous clear cycle, optionally with a push that must be ignored.
  task automatic applyClear(input logic v, input logic [7:0] a);
    clr_i          = 1'b1;
    xxx_dt_valid_i = v;
    xxx_addr_i     = a;
    xxx_dt_i       = 8'h55;
    out_ready_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_i          = 1'b0;
    xxx_dt_valid_i = 1'b0;
    out_ready_i    = 1'b0;
    sb.delete();
    checkOutput("clrLevel", 32'(level_o), 32'h0);
    checkOutput("clrValid", 32'(out_valid_o), 32'h0);
    checkOutput("clrOvf", 32'(ovf_o), 32'h0);
    checkOutput("clrDrop", 32'(drop_cnt_o), 32'h0);
    checkOutput("clrSeq", 32'(seq_err_o), 32'h0);
  endtask

  // Directed sequence covering ordering, overflow, sequence checks, clear and reset.
  initial begin
    rst = 1'b1; clr_i = 1'b0;
    xxx_dt_valid_i = 1'b0; xxx_addr_i = '0; xxx_dt_i = '0; out_ready_i = 1'b0;
    v2 = 1'b0; a2 = '0; d2 = '0; ready2 = 1'b0;

    #3;
    checkOutput("rstValid", 32'(out_valid_o), 32'h0);
    checkOutput("rstLevel", 32'(level_o), 32'h0);
    checkOutput("rstOvf", 32'(ovf_o), 32'h0);
    checkOutput("rstDrop", 32'(drop_cnt_o), 32'h0);
    checkOutput("rstSeq", 32'(seq_err_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // In-order streaming with ready held high.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i), 8'(8'hA0 + i), 1'b1);
    applyStimulus(1'b0, 8'h0, 8'h0, 1'b1);
    applyStimulus(1'b0, 8'h0, 8'h0, 1'b1);
    checkOutput("t1Seq", 32'(seq_err_o), 32'h0);

    // Overfill with ready low: two samples lost, first eight drain in order.
    for (int i = 4; i < 14; i++) applyStimulus(1'b1, 8'(i), 8'(8'hB0 + i), 1'b0);
    checkOutput("t2Level", 32'(level_o), 32'd8);
    checkOutput("t2Ovf", 32'(ovf_o), 32'h1);
    checkOutput("t2Drop", 32'(drop_cnt_o), 32'd2);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h0, 8'h0, 1'b1);
    checkOutput("t2Empty", 32'(level_o), 32'h0);

    // Push against a full buffer while popping: sample lost, level drops by one.
    for (int i = 14; i < 22; i++) applyStimulus(1'b1, 8'(i), 8'(8'hC0 + i), 1'b0);
    applyStimulus(1'b1, 8'd22, 8'hD6, 1'b1);
    checkOutput("t3Level", 32'(level_o), 32'd7);
    checkOutput("t3Drop", 32'(drop_cnt_o), 32'd3);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h0, 8'h0, 1'b1);

    // Address wrap is legal, a jump is flagged and sticks until clear.
    applyClear(1'b1, 8'h50);
    applyStimulus(1'b1, 8'hFE, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'hFF, 8'h12, 1'b1);
    applyStimulus(1'b1, 8'h00, 8'h13, 1'b1);
    checkOutput("t4WrapOk", 32'(seq_err_o), 32'h0);
    applyStimulus(1'b1, 8'h05, 8'h14, 1'b1);
    checkOutput("t4Jump", 32'(seq_err_o), 32'h1);
    applyStimulus(1'b1, 8'h06, 8'h15, 1'b1);
    checkOutput("t4Sticky", 32'(seq_err_o), 32'h1);
    applyStimulus(1'b0, 8'h0, 8'h0, 1'b1);
    applyClear(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h07, 8'h16, 1'b1);
    applyStimulus(1'b1, 8'h08, 8'h17, 1'b1);
    checkOutput("t4AfterClr", 32'(seq_err_o), 32'h0);
    applyStimulus(1'b0, 8'h0, 8'h0, 1'b1);
    applyStimulus(1'b0, 8'h0, 8'h0, 1'b0);

    // Two-bit drop counter: five drops must pin at 3 rather than wrap.
    for (int i = 0; i < 13; i++) begin
      v2 = 1'b1; a2 = 8'(i); d2 = 8'(i);
      @(posedge clk);
      @(negedge clk);
      if (i == 9) checkOutput("t5DropMid", 32'(drop2), 32'd2);
    end
    v2 = 1'b0;
    checkOutput("t5DropSat", 32'(drop2), 32'd3);
    checkOutput("t5Ovf", 32'(ovf2), 32'h1);
    checkOutput("t5Level", 32'(level2), 32'd8);

    // Asynchronous reset in the middle of a drain with five entries held.
    for (int i = 9; i < 15; i++) applyStimulus(1'b1, 8'(i), 8'(8'hE0 + i), 1'b0);
    applyStimulus(1'b0, 8'h0, 8'h0, 1'b1);
    checkOutput("t6Level5", 32'(level_o), 32'd5);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("t6RstValid", 32'(out_valid_o), 32'h0);
    checkOutput("t6RstLevel", 32'(level_o), 32'h0);
    checkOutput("t6RstAddr", 32'(out_addr_o), 32'h0);
    checkOutput("t6RstData", 32'(out_dt_o), 32'h0);
    checkOutput("t6RstDrop2", 32'(drop2), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6PostValid", 32'(out_valid_o), 32'h0);
    applyStimulus(1'b1, 8'h20, 8'h33, 1'b0);
    applyStimulus(1'b0, 8'h0, 8'h0, 1'b1);
    applyStimulus(1'b0, 8'h0, 8'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
